// File: rtl/gpio_bus_responder.sv
// gpio_bus_responder: memory-mapped GPIO target on the CPU data bus.
// Drives 8 LEDs, debounces 8 switches, latches switch edges.
// Optional feature macro: GPIO_IRQ_EN (IRQEN register + irq output).
// Ports:
//   ClkIn, Rst      clock, async active-high reset
//   bus_req/we      request valid / store select
//   bus_addr        byte offset [3:0], word select on [3:2]
//   bus_wdata       store data, [7:0] used
//   bus_rdata       load data during bus_ack, else 0
//   bus_ack         one-cycle completion pulse
//   switch          raw async switch inputs
//   led             LED register
//   irq             |(EDGE & IRQEN), registered (0 without macro)
module gpio_bus_responder #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16,
  parameter logic [7:0]  LED_RST         = 8'h00
) (
  input  logic        ClkIn,
  input  logic        Rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;

  logic [7:0]  r_led;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_sw;
  logic [7:0]  r_edge;
  logic [31:0] r_rdata;
  logic [7:0][CNT_W-1:0] r_cnt;

  logic [7:0]  w_sw_nxt;
  logic [7:0][CNT_W-1:0] w_cnt_nxt;
  logic [7:0]  w_edge_set;
  logic [7:0]  w_edge_clr;
  logic [7:0]  w_irqen;
  logic [7:0]  w_rd_val;
  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_unused;

  assign w_unused = ^{bus_wdata[31:8], bus_addr[1:0]};
  assign w_sel    = bus_addr[3:2];
  assign w_wr     = w_accept & bus_we;

  // ---------------- bus FSM ----------------
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // WAIT keeps a held request from retriggering.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus_req) begin
          w_state_nxt = S_ACK;
          w_accept    = 1'b1;
        end
      end
      S_ACK:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!bus_req) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus_ack   = (r_state == S_ACK);
  assign bus_rdata = bus_ack ? r_rdata : 32'h0;

  // ---------------- read mux ----------------
  always_comb begin
    w_rd_val = 8'h00;
    unique case (w_sel)
      2'd0: w_rd_val = r_led;
      2'd1: w_rd_val = r_sw;
      2'd2: w_rd_val = r_edge;
      2'd3: w_rd_val = w_irqen;
      default: w_rd_val = 8'h00;
    endcase
  end

  // Captured from pre-update SW, so a load never sees
  // a same-cycle debounce change.
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst)
      r_rdata <= 32'h0;
    else if (w_accept && !bus_we)
      r_rdata <= {24'h0, w_rd_val};
  end

  // ---------------- LED ----------------
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst)
      r_led <= LED_RST;
    else if (w_wr && w_sel == 2'd0)
      r_led <= bus_wdata[7:0];
  end

  assign led = r_led;

  // ---------------- switch path ----------------
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= switch;
      r_sync2 <= r_sync1;
    end
  end

  // Counter runs only while sync differs from debounced;
  // any return to agreement restarts the hold window.
  always_comb begin
    w_sw_nxt  = r_sw;
    w_cnt_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_sync2[i] != r_sw[i]) begin
        if (r_cnt[i] == CNT_MAX)
          w_sw_nxt[i] = r_sync2[i];
        else
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      r_sw  <= 8'h00;
      r_cnt <= '0;
    end else begin
      r_sw  <= w_sw_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // ---------------- edge latch ----------------
  assign w_edge_set = w_sw_nxt ^ r_sw;
  assign w_edge_clr =
    (w_wr && w_sel == 2'd2) ? bus_wdata[7:0] : 8'h00;

  // Set is OR'd after clear so a new edge wins over W1C.
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst)
      r_edge <= 8'h00;
    else
      r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
  end

  // ---------------- interrupt ----------------
`ifdef GPIO_IRQ_EN
  logic [7:0] r_irqen;
  logic       r_irq;

  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst)
      r_irqen <= 8'h00;
    else if (w_wr && w_sel == 2'd3)
      r_irqen <= bus_wdata[7:0];
  end

  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) r_irq <= 1'b0;
    else     r_irq <= |(r_edge & r_irqen);
  end

  assign w_irqen = r_irqen;
  assign irq     = r_irq;
`else
  assign w_irqen = 8'h00;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bus_responder.sv
// tb_gpio_bus_responder: directed bench with a
// queue-based scoreboard and a negedge bus monitor.
module tb_gpio_bus_responder;

  logic        ClkIn;
  logic        Rst;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic        irq;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  gpio_bus_responder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .LED_RST(8'h00)
  ) dut (
    .ClkIn(ClkIn),
    .Rst(Rst),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .switch(switch),
    .led(led),
    .irq(irq)
  );

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  typedef struct {
    logic        is_store;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_acks   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation.
  always @(negedge ClkIn) begin : mon
    exp_t e;
    if (!Rst && bus_ack) begin
      n_acks++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        if (!e.is_store) begin
          checks++;
          if (bus_rdata !== e.data) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h",
                     e.name, bus_rdata, e.data);
          end
        end
      end
    end else if (!Rst) begin
      checks++;
      if (bus_rdata !== 32'h0) begin
        failures++;
        $display("FAIL rdata_idle actual=%h expected=0",
                 bus_rdata);
      end
    end
  end

  // Called just after a rising edge; returns just after
  // a rising edge with the FSM back in IDLE.
  task automatic access(input logic        we,
                        input logic [3:0]  addr,
                        input logic [31:0] wd,
                        input logic [31:0] exp_rd,
                        input string       nm);
    exp_q.push_back('{we, exp_rd, nm});
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    @(posedge ClkIn);
    @(negedge ClkIn);
    chk({"ack_lat_", nm}, {31'h0, bus_ack}, 32'h1);
    @(posedge ClkIn);
    #1;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = 32'h0;
    @(posedge ClkIn);
    #1;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d,
                    input string nm);
    access(1'b1, a, d, 32'h0, nm);
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [31:0] e,
                    input string nm);
    access(1'b0, a, 32'h0, e, nm);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ClkIn);
    #1;
  endtask

  int n0;

  initial begin
    Rst       = 1'b1;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 4'h0;
    bus_wdata = 32'h0;
    switch    = 8'h00;
    #100;
    Rst = 1'b0;
    cyc(1);

    // reset state
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_ack", {31'h0, bus_ack}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd(4'h4, 32'h0, "rst_sw");
    rd(4'h8, 32'h0, "rst_edge");
    rd(4'hC, 32'h0, "rst_irqen");

    // LED write / readback
    wr(4'h0, 32'h0000_00A5, "st_led");
    chk("led_a5", {24'h0, led}, 32'hA5);
    rd(4'h0, 32'h0000_00A5, "ld_led");
    rd(4'h1, 32'h0000_00A5, "ld_led_lowbits");

    // debounced switch + edge
    switch = 8'h01;
    cyc(8);
    rd(4'h4, 32'h01, "sw_01");
    rd(4'h8, 32'h01, "edge_01");

    // 3-cycle glitch on bit1 is filtered
    switch = 8'h03;
    cyc(3);
    switch = 8'h01;
    cyc(6);
    rd(4'h4, 32'h01, "sw_glitch");
    rd(4'h8, 32'h01, "edge_glitch");

    // W1C in the same cycle as a new bit0 edge
    switch = 8'h00;
    cyc(5);
    wr(4'h8, 32'h1, "w1c_race");
    rd(4'h8, 32'h01, "edge_set_wins");
    rd(4'h4, 32'h00, "sw_00");
    wr(4'h8, 32'h1, "w1c_alone");
    rd(4'h8, 32'h00, "edge_cleared");

    // writes to RO offset ignored
    wr(4'h4, 32'hFF, "st_ro");
    rd(4'h4, 32'h00, "sw_ro_kept");

    // held request acks once
    n0 = n_acks;
    exp_q.push_back('{1'b0, 32'hA5, "held_ld"});
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 4'h0;
    cyc(5);
    bus_req = 1'b0;
    cyc(2);
    chk("held_one_ack", n_acks - n0, 32'd1);

    // reset during ACK cycle
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 4'h0;
    bus_wdata = 32'h3C;
    @(posedge ClkIn);
    #1;
    chk("pre_rst_ack", {31'h0, bus_ack}, 32'h1);
    chk("pre_rst_led", {24'h0, led}, 32'h3C);
    #1;
    Rst     = 1'b1;
    bus_req = 1'b0;
    bus_we  = 1'b0;
    #1;
    chk("rst_mid_ack", {31'h0, bus_ack}, 32'h0);
    chk("rst_mid_led", {24'h0, led}, 32'h0);
    cyc(2);
    #2;
    Rst = 1'b0;
    cyc(1);
    rd(4'h0, 32'h0, "led_after_rst");

    // interrupt
    wr(4'hC, 32'h01, "st_irqen");
    rd(4'hC, IRQ_ON ? 32'h01 : 32'h0, "ld_irqen");
    chk("irq_idle", {31'h0, irq}, 32'h0);
    switch = 8'h01;
    cyc(6);
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    cyc(1);
    chk("irq_set", {31'h0, irq}, {31'h0, IRQ_ON});
    wr(4'h8, 32'h1, "w1c_irq");
    chk("irq_clr", {31'h0, irq}, 32'h0);
    rd(4'h8, 32'h0, "edge_after_irq");

    cyc(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
